// File: rtl/pdm_xcorr_pkg.sv
// pdm_xcorr_pkg
// Shared definitions for the cross-correlation lag tracker:
//   state_t      - tracker FSM state encoding
//   lag_t        - signed lag estimate at the default lag width
//   win_log2()   - log2 of the decision window length (window is a power of two)
package pdm_xcorr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    localparam int LAG_W_DEF = 6;
    typedef logic signed [LAG_W_DEF-1:0] lag_t;

    localparam int WINDOW_DEF = 256;

    function automatic int win_log2(input int window);
        return $clog2(window);
    endfunction

    localparam int WIN_LOG2_DEF = win_log2(WINDOW_DEF);

endpackage

// File: rtl/xcorr_window_accum.sv
// xcorr_window_accum
// Integrates per-cycle lead/lag votes and the mismatch count over one window.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   clear       - zero all totals (has priority over accum)
//   accum       - add this cycle's sample to the totals
//   pos, neg    - lead/lag votes; both may be set in the same cycle
//   corr        - mismatch count for this cycle
//   done        - high while accum adds the final sample of the window
//   pos_cnt     - number of pos votes so far
//   neg_cnt     - number of neg votes so far
//   corr_acc    - sum of corr so far
module xcorr_window_accum
    import pdm_xcorr_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        accum,
    input  logic                        pos,
    input  logic                        neg,
    input  logic [7:0]                  corr,
    output logic                        done,
    output logic [$clog2(WINDOW):0]     pos_cnt,
    output logic [$clog2(WINDOW):0]     neg_cnt,
    output logic [$clog2(WINDOW)+7:0]   corr_acc
);

    localparam int WL = win_log2(WINDOW);
    localparam int CW = WL + 1;
    localparam int AW = WL + 8;

    logic [CW-1:0] win_cnt;

    assign done = accum && (win_cnt == CW'(WINDOW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_cnt  <= '0;
            neg_cnt  <= '0;
            corr_acc <= '0;
            win_cnt  <= '0;
        end else if (clear) begin
            pos_cnt  <= '0;
            neg_cnt  <= '0;
            corr_acc <= '0;
            win_cnt  <= '0;
        end else if (accum) begin
            pos_cnt  <= pos_cnt + CW'(pos);
            neg_cnt  <= neg_cnt + CW'(neg);
            corr_acc <= corr_acc + AW'(corr);
            win_cnt  <= win_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/xcorr_lag_tracker.sv
// xcorr_lag_tracker
// Integrates lead/lag votes over fixed windows and steps a signed lag estimate
// by at most one per window; also reports the window-mean mismatch and lock.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   enable      - tracking enable; dropping it aborts the current window
//   clear_lag   - one-cycle request forcing lag and lock history to zero
//   length      - correlation length programmed upstream (settle time)
//   pos, neg    - per-cycle lead/lag votes
//   corr        - per-cycle mismatch count
//   lag         - signed lag estimate
//   lag_valid   - one-cycle pulse when lag/corr_mean were just updated
//   corr_mean   - mean corr of the last completed window
//   locked      - lag has not stepped for LOCK_COUNT consecutive windows
//
// state  | meaning
// IDLE   | tracking off, outputs hold
// SETTLE | waiting `length` cycles for the upstream buffer to refill
// ACCUM  | integrating one window of samples
// DECIDE | apply step to lag, publish corr_mean; sample this cycle discarded
module xcorr_lag_tracker
    import pdm_xcorr_pkg::*;
#(
    parameter int WINDOW     = WINDOW_DEF,
    parameter int THRESH     = 16,
    parameter int LAG_W      = LAG_W_DEF,
    parameter int MAX_LAG    = 31,
    parameter int LOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    clear_lag,
    input  logic [7:0]              length,
    input  logic                    pos,
    input  logic                    neg,
    input  logic [7:0]              corr,
    output logic signed [LAG_W-1:0] lag,
    output logic                    lag_valid,
    output logic [7:0]              corr_mean,
    output logic                    locked
);

    localparam int WL = win_log2(WINDOW);
    localparam int CW = WL + 1;
    localparam int DW = CW + 1;
    localparam int AW = WL + 8;
    localparam int SW = $clog2(LOCK_COUNT + 1);

    localparam logic signed [DW-1:0]    THR     = DW'(THRESH);
    localparam logic signed [LAG_W-1:0] LAG_MAX = LAG_W'(MAX_LAG);
    localparam logic signed [LAG_W-1:0] LAG_MIN = -LAG_MAX;

    state_t          state, state_nxt;
    logic [7:0]      settle_cnt;
    logic            acc_clear, acc_en, acc_done;
    logic [CW-1:0]   pos_cnt, neg_cnt;
    logic [AW-1:0]   corr_acc;
    logic [SW-1:0]   stable_cnt;
    logic signed [DW-1:0] diff;
    logic            step_up, step_dn;

    xcorr_window_accum #(.WINDOW(WINDOW)) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (acc_clear),
        .accum    (acc_en),
        .pos      (pos),
        .neg      (neg),
        .corr     (corr),
        .done     (acc_done),
        .pos_cnt  (pos_cnt),
        .neg_cnt  (neg_cnt),
        .corr_acc (corr_acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Totals are held cleared outside ACCUM, so an aborted window never leaks
    // into the next one.
    always_comb begin
        state_nxt = state;
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                acc_clear = 1'b1;
                if (enable) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                acc_clear = 1'b1;
                if (!enable)                state_nxt = ST_IDLE;
                else if (settle_cnt <= 8'd1) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (!enable) begin
                    acc_clear = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    acc_en = 1'b1;
                    if (acc_done) state_nxt = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                acc_clear = 1'b1;
                state_nxt = enable ? ST_ACCUM : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Settle timer: loaded on leaving IDLE, a zero length still waits one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == ST_IDLE && enable) begin
            settle_cnt <= (length == 8'd0) ? 8'd1 : length;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt - 8'd1;
        end
    end

    assign diff    = $signed({1'b0, pos_cnt}) - $signed({1'b0, neg_cnt});
    assign step_up = diff > THR;
    assign step_dn = diff < -THR;

    // A step requested at a saturation bound leaves lag alone but still
    // resets the stability count, so a pinned lag never reports lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lag        <= '0;
            lag_valid  <= 1'b0;
            corr_mean  <= '0;
            stable_cnt <= '0;
        end else begin
            lag_valid <= (state == ST_DECIDE);
            if (state == ST_DECIDE) corr_mean <= 8'(corr_acc >> WL);
            if (clear_lag) begin
                lag        <= '0;
                stable_cnt <= '0;
            end else if (state == ST_DECIDE) begin
                if (step_up) begin
                    stable_cnt <= '0;
                    if (lag != LAG_MAX) lag <= lag + LAG_W'(1);
                end else if (step_dn) begin
                    stable_cnt <= '0;
                    if (lag != LAG_MIN) lag <= lag - LAG_W'(1);
                end else if (stable_cnt != SW'(LOCK_COUNT)) begin
                    stable_cnt <= stable_cnt + SW'(1);
                end
            end
        end
    end

    assign locked = (stable_cnt >= SW'(LOCK_COUNT));

endmodule

// File: tb/tb_xcorr_lag_tracker.sv
// tb_xcorr_lag_tracker
// Randomized and directed windows checked against a window-level model of the
// tracker (vote sums, threshold, clamp, lock history).
module tb_xcorr_lag_tracker;

    localparam int WINDOW     = 16;
    localparam int THRESH     = 4;
    localparam int LAG_W      = 6;
    localparam int MAX_LAG    = 31;
    localparam int LOCK_COUNT = 2;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic                    clear_lag;
    logic [7:0]              length;
    logic                    pos;
    logic                    neg;
    logic [7:0]              corr;
    logic signed [LAG_W-1:0] lag;
    logic                    lag_valid;
    logic [7:0]              corr_mean;
    logic                    locked;

    always #5 clk = ~clk;

    xcorr_lag_tracker #(
        .WINDOW     (WINDOW),
        .THRESH     (THRESH),
        .LAG_W      (LAG_W),
        .MAX_LAG    (MAX_LAG),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .clear_lag (clear_lag),
        .length    (length),
        .pos       (pos),
        .neg       (neg),
        .corr      (corr),
        .lag       (lag),
        .lag_valid (lag_valid),
        .corr_mean (corr_mean),
        .locked    (locked)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // reference model state
    int lag_m    = 0;
    int stable_m = 0;
    int cmean_m  = 0;

    bit         pos_a [WINDOW];
    bit         neg_a [WINDOW];
    logic [7:0] corr_a[WINDOW];

    task automatic model_window(input bit clr);
        int pc, nc, cs, d, step;
        pc = 0; nc = 0; cs = 0;
        for (int i = 0; i < WINDOW; i++) begin
            pc += int'(pos_a[i]);
            nc += int'(neg_a[i]);
            cs += int'(corr_a[i]);
        end
        d    = pc - nc;
        step = (d > THRESH) ? 1 : ((d < -THRESH) ? -1 : 0);
        cmean_m = cs / WINDOW;
        if (clr) begin
            lag_m    = 0;
            stable_m = 0;
        end else if (step != 0) begin
            stable_m = 0;
            lag_m    = lag_m + step;
            if (lag_m > MAX_LAG)  lag_m = MAX_LAG;
            if (lag_m < -MAX_LAG) lag_m = -MAX_LAG;
        end else if (stable_m < LOCK_COUNT) begin
            stable_m++;
        end
    endtask

    task automatic fill_directed(input int np, input int nn, input int c);
        for (int i = 0; i < WINDOW; i++) begin
            pos_a[i]  = (i < np);
            neg_a[i]  = (i >= WINDOW - nn);
            corr_a[i] = (c < 0) ? 8'($urandom_range(0, 255)) : 8'(c);
        end
    endtask

    task automatic fill_random(input int pp, input int pn);
        for (int i = 0; i < WINDOW; i++) begin
            pos_a[i]  = ($urandom_range(0, 99) < pp);
            neg_a[i]  = ($urandom_range(0, 99) < pn);
            corr_a[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Call at a negedge while IDLE; returns at the negedge where sample 0 goes.
    // Inputs during settle are deliberately skewed so a wrong settle length
    // shows up as a shifted or corrupted window.
    task automatic start(input int len);
        int eff;
        eff    = (len == 0) ? 1 : len;
        enable = 1'b1;
        length = 8'(len);
        pos    = 1'b0;
        neg    = 1'b1;
        corr   = 8'd255;
        repeat (eff + 1) @(negedge clk);
    endtask

    // Call at the negedge for sample 0; returns at the negedge for the next
    // window's sample 0 (the cycle in which lag_valid is high).
    task automatic run_window(input string tag, input bit clr);
        for (int i = 0; i < WINDOW; i++) begin
            if (i > 0) @(negedge clk);
            pos    = pos_a[i];
            neg    = neg_a[i];
            corr   = corr_a[i];
            length = 8'($urandom_range(0, 255));
            if (i == 1) chk({tag, " valid_one_cycle"}, int'(lag_valid), 0);
        end
        @(negedge clk);
        chk({tag, " valid_early"}, int'(lag_valid), 0);
        pos       = 1'($urandom_range(0, 1));
        neg       = 1'($urandom_range(0, 1));
        corr      = 8'($urandom_range(0, 255));
        clear_lag = clr;
        @(negedge clk);
        clear_lag = 1'b0;
        model_window(clr);
        chk({tag, " valid"},     int'(lag_valid), 1);
        chk({tag, " lag"},       int'(lag),       lag_m);
        chk({tag, " corr_mean"}, int'(corr_mean), cmean_m);
        chk({tag, " locked"},    int'(locked),    int'(stable_m >= LOCK_COUNT));
    endtask

    initial begin
        int vcnt;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear_lag = 1'b0;
        length    = 8'd0;
        pos       = 1'b0;
        neg       = 1'b0;
        corr      = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset lag",       int'(lag),       0);
        chk("reset valid",     int'(lag_valid), 0);
        chk("reset corr_mean", int'(corr_mean), 0);
        chk("reset locked",    int'(locked),    0);
        rst_n = 1'b1;
        @(negedge clk);

        // settle of 5, then two full pos windows
        start(5);
        fill_directed(16, 0, 8);
        run_window("step_up1", 1'b0);
        run_window("step_up2", 1'b0);

        // dead band twice (lock), then just over threshold
        fill_directed(10, 6, -1);
        run_window("dead1", 1'b0);
        fill_directed(10, 6, -1);
        run_window("dead2", 1'b0);
        fill_directed(11, 5, -1);
        run_window("over", 1'b0);

        // abort at sample 9
        fill_directed(16, 0, 8);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            pos  = pos_a[i];
            neg  = neg_a[i];
            corr = corr_a[i];
        end
        @(negedge clk);
        enable = 1'b0;
        vcnt   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vcnt += int'(lag_valid);
        end
        chk("abort valid_count", vcnt, 0);
        chk("abort lag_hold",    int'(lag), lag_m);

        // re-settle, then clear_lag coinciding with a +1 decision
        start(3);
        fill_directed(16, 0, 40);
        run_window("clr_decide", 1'b1);

        // saturation towards -MAX_LAG
        for (int w = 0; w < 40; w++) begin
            fill_directed(0, 16, 100);
            run_window($sformatf("sat%0d", w), 1'b0);
        end
        chk("sat final_lag", int'(lag), -MAX_LAG);

        // asynchronous reset in the middle of a window
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async lag",       int'(lag),       0);
        chk("async valid",     int'(lag_valid), 0);
        chk("async corr_mean", int'(corr_mean), 0);
        chk("async locked",    int'(locked),    0);
        enable = 1'b0;
        lag_m = 0; stable_m = 0; cmean_m = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero length settles for one cycle; random windows with random clears
        start(0);
        for (int w = 0; w < 30; w++) begin
            fill_random($urandom_range(0, 100), $urandom_range(0, 100));
            run_window($sformatf("rand%0d", w), ($urandom_range(0, 7) == 0));
        end

        enable = 1'b0;
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
